cache_mem_bridge: RTL and testbench
===================================

CACHE_MEM_BRIDGE -- requirements
Module: cache_mem_bridge

Interface
REQ-001 Parameter TAG_W, default 21, cache tag width (32 - IDX_W - 5).
REQ-002 Parameter IDX_W, default 6, cache set-index width.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting for mem_ack_in before abort.
REQ-004 Single clock and reset: the block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ram_en_in  in  1  word transfer requested by cache controller.
REQ-008 ram_write_in  in  1  1 = write-back word to memory, 0 = refill read.
REQ-009 ram_addr_sel_in  in  2  00 = I-cache line, 01 = D-cache line, 11 = D-cache victim line, 10 = treated as 00.
REQ-010 counter_in  in  3  word index within 8-word line.
REQ-011 ic_addr_in  in  32  I-side byte address.
REQ-012 dc_addr_in  in  32  D-side byte address.
REQ-013 dc_victim_tag_in  in  TAG_W  tag of the dirty line being evicted.
REQ-014 wdata_in  in  32  cache word to write back.
REQ-015 mem_addr_out  out  32  word-aligned memory byte address.
REQ-016 mem_wdata_out  out  32  write data to memory.
REQ-017 mem_req_out  out  1  request, held until acknowledged.
REQ-018 mem_we_out  out  1  write strobe qualifying mem_req_out.
REQ-019 mem_ack_in  in  1  memory accepts write / returns read data this cycle.
REQ-020 mem_rdata_in  in  32  read data, valid with mem_ack_in.
REQ-021 rdata_out  out  32  captured refill word for cache data input.
REQ-022 word_done_out  out  1  one-cycle pulse; controller advances counter only on it.
REQ-023 busy_out  out  1  stall to pipeline while a transfer is outstanding.
REQ-024 timeout_out  out  1  sticky error flag.

Function
REQ-025 Line base SHALL be: sel 00/10 -> {ic_addr_in[31:5],5'b0}; sel 01 -> {dc_addr_in[31:5],5'b0}; sel 11 -> {dc_victim_tag_in, dc_addr_in[IDX_W+4:5], 5'b0}.
REQ-026 mem_addr_out SHALL be base | {counter_in,2'b00}, latched at request start and held stable during the transfer.
REQ-027 FSM states SHALL be IDLE, REQ, DONE.
REQ-028 IDLE: when ram_en_in=1, the block SHALL latch address, wdata_in and ram_write_in, and enter REQ.
REQ-029 REQ: mem_req_out=1 and mem_we_out=latched write; on mem_ack_in=1, capture mem_rdata_in into rdata_out (reads only) and enter DONE.
REQ-030 DONE: word_done_out=1 for exactly one cycle; the block SHALL return to IDLE unconditionally, giving a one-cycle bubble for the counter register to update.
REQ-031 Minimum latency SHALL be: ram_en_in at T -> mem_req_out at T+1 -> ack at T+1 -> word_done_out at T+2 -> IDLE at T+3.
REQ-032 An ack arriving in the first REQ cycle SHALL be honoured; mem_ack_in outside REQ SHALL be ignored.
REQ-033 Deasserting ram_en_in during REQ SHALL NOT abort the transfer.
REQ-034 rdata_out SHALL hold its value until the next read capture; writes SHALL leave it unchanged.
REQ-035 busy_out SHALL be 1 in REQ and 0 in IDLE and DONE.
REQ-036 An 8-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-037 On reaching TIMEOUT, the block SHALL set timeout_out, drop mem_req_out, load rdata_out=32'hDEADBEEF for reads, and enter DONE.
REQ-038 timeout_out SHALL clear only on rst.

Reset
REQ-039 rst SHALL force IDLE at the next edge, including mid-transfer, with no completion pulse.
REQ-040 Reset values SHALL be: mem_req_out=0, mem_we_out=0, word_done_out=0, busy_out=0, timeout_out=0, mem_addr_out=0, mem_wdata_out=0, rdata_out=0, wait counter=0.

Structure
REQ-041 The shared header status.vh SHALL hold the ram_addr_sel encodings, line size (8 words) and bridge state encodings.
REQ-042 Address formation SHALL be one combinational sub-module, cache_addr_gen; the FSM, latches and timer live in cache_mem_bridge.

Verification
REQ-043 Read, immediate ack: sel 00, ic_addr 0x00401234, counter 3, ack at T+1 with 0xCAFEF00D -> mem_addr 0x0040122C, word_done at T+2, rdata_out 0xCAFEF00D.
REQ-044 Write-back with 3 wait cycles: sel 11, victim tag 0x1ABCD, dc_addr index 0x15, counter 7, wdata 0x12345678 -> mem_addr {0x1ABCD,6'h15,5'h1C}, we=1, req held 4 cycles, rdata_out unchanged.
REQ-045 Full 8-word refill with counter advanced on each word_done -> 8 requests at +0x00..+0x1C, 8 pulses, no overlap.
REQ-046 No ack for 255 cycles -> timeout_out=1, rdata_out 0xDEADBEEF, word_done pulse; next transfer still works and timeout_out stays 1.
REQ-047 rst asserted in REQ, then ack -> IDLE next edge, req=0, no word_done; stray ack ignored.

Source files
------------

// File: rtl/cache_mem_bridge_pkg.sv
// Shared encodings for the cache/memory word-transfer bridge: address
// select codes, line geometry and bridge FSM states.
package cache_mem_bridge_pkg;

    typedef enum logic [1:0] {
        SEL_IC     = 2'b00,
        SEL_DC     = 2'b01,
        SEL_IC_ALT = 2'b10,
        SEL_VICTIM = 2'b11
    } ram_addr_sel_t;

    localparam int unsigned LINE_WORDS = 8;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } bridge_state_t;

endpackage

// File: rtl/cache_addr_gen.sv
// Combinational memory word address: line base selected by source, OR'd
// with the word index inside the 8-word line.
module cache_addr_gen
    import cache_mem_bridge_pkg::*;
#(
    parameter int unsigned TAG_W = 21,
    parameter int unsigned IDX_W = 6
) (
    input  logic [1:0]       ram_addr_sel_in,
    input  logic [2:0]       counter_in,
    input  logic [31:0]      ic_addr_in,
    input  logic [31:0]      dc_addr_in,
    input  logic [TAG_W-1:0] dc_victim_tag_in,
    output logic [31:0]      addr_out
);

    logic [31:0] line_base;
    // Byte offsets are replaced by the word counter, so they are never used.
    logic        unused_offset_bits;

    assign unused_offset_bits = ^{ic_addr_in[4:0], dc_addr_in[4:0]};

    always_comb begin
        line_base = {ic_addr_in[31:5], 5'b0};
        case (ram_addr_sel_in)
            SEL_DC:     line_base = {dc_addr_in[31:5], 5'b0};
            SEL_VICTIM: line_base = {dc_victim_tag_in, dc_addr_in[IDX_W+4:5], 5'b0};
            default:    line_base = {ic_addr_in[31:5], 5'b0};
        endcase
    end

    assign addr_out = line_base | {27'b0, counter_in, 2'b00};

endmodule

// File: rtl/cache_mem_bridge.sv
// Single-word transfer bridge between the cache controllers and memory:
// IDLE -> REQ (held until ack or timeout) -> DONE (one-cycle completion pulse).
module cache_mem_bridge
    import cache_mem_bridge_pkg::*;
#(
    parameter int unsigned TAG_W   = 21,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ram_en_in,
    input  logic             ram_write_in,
    input  logic [1:0]       ram_addr_sel_in,
    input  logic [2:0]       counter_in,
    input  logic [31:0]      ic_addr_in,
    input  logic [31:0]      dc_addr_in,
    input  logic [TAG_W-1:0] dc_victim_tag_in,
    input  logic [31:0]      wdata_in,
    output logic [31:0]      mem_addr_out,
    output logic [31:0]      mem_wdata_out,
    output logic             mem_req_out,
    output logic             mem_we_out,
    input  logic             mem_ack_in,
    input  logic [31:0]      mem_rdata_in,
    output logic [31:0]      rdata_out,
    output logic             word_done_out,
    output logic             busy_out,
    output logic             timeout_out
);

    // Abort fires on the REQ cycle whose increment would reach TIMEOUT,
    // so the request is held for exactly TIMEOUT unacknowledged cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    bridge_state_t state, state_nxt;
    logic [31:0]   gen_addr;
    logic [7:0]    wait_cnt;
    logic          we_q;
    logic          tmo_hit;
    logic          start;

    cache_addr_gen #(
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .ram_addr_sel_in  (ram_addr_sel_in),
        .counter_in       (counter_in),
        .ic_addr_in       (ic_addr_in),
        .dc_addr_in       (dc_addr_in),
        .dc_victim_tag_in (dc_victim_tag_in),
        .addr_out         (gen_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        mem_req_out   = 1'b0;
        mem_we_out    = 1'b0;
        busy_out      = 1'b0;
        word_done_out = 1'b0;
        tmo_hit       = 1'b0;
        start         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ram_en_in) begin
                    start     = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_out = 1'b1;
                mem_we_out  = we_q;
                busy_out    = 1'b1;
                if (mem_ack_in) begin
                    state_nxt = ST_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                word_done_out = 1'b1;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            rdata_out     <= '0;
            we_q          <= 1'b0;
            wait_cnt      <= '0;
            timeout_out   <= 1'b0;
        end else begin
            if (start) begin
                mem_addr_out  <= gen_addr;
                mem_wdata_out <= wdata_in;
                we_q          <= ram_write_in;
                wait_cnt      <= '0;
            end else if (state == ST_REQ && !mem_ack_in) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == ST_REQ && mem_ack_in && !we_q) rdata_out <= mem_rdata_in;
            if (tmo_hit) begin
                timeout_out <= 1'b1;
                if (!we_q) rdata_out <= TIMEOUT_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Self-checking bench for cache_mem_bridge: directed scenarios plus random
// transfers checked against a transaction-level address/data model.
module tb_cache_mem_bridge;

    localparam int unsigned TAG_W   = 21;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             ram_en_in;
    logic             ram_write_in;
    logic [1:0]       ram_addr_sel_in;
    logic [2:0]       counter_in;
    logic [31:0]      ic_addr_in;
    logic [31:0]      dc_addr_in;
    logic [TAG_W-1:0] dc_victim_tag_in;
    logic [31:0]      wdata_in;
    logic [31:0]      mem_addr_out;
    logic [31:0]      mem_wdata_out;
    logic             mem_req_out;
    logic             mem_we_out;
    logic             mem_ack_in;
    logic [31:0]      mem_rdata_in;
    logic [31:0]      rdata_out;
    logic             word_done_out;
    logic             busy_out;
    logic             timeout_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rdata_exp;
    logic        tmo_exp;

    cache_mem_bridge #(
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ram_en_in        (ram_en_in),
        .ram_write_in     (ram_write_in),
        .ram_addr_sel_in  (ram_addr_sel_in),
        .counter_in       (counter_in),
        .ic_addr_in       (ic_addr_in),
        .dc_addr_in       (dc_addr_in),
        .dc_victim_tag_in (dc_victim_tag_in),
        .wdata_in         (wdata_in),
        .mem_addr_out     (mem_addr_out),
        .mem_wdata_out    (mem_wdata_out),
        .mem_req_out      (mem_req_out),
        .mem_we_out       (mem_we_out),
        .mem_ack_in       (mem_ack_in),
        .mem_rdata_in     (mem_rdata_in),
        .rdata_out        (rdata_out),
        .word_done_out    (word_done_out),
        .busy_out         (busy_out),
        .timeout_out      (timeout_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Address from the source rules: line base of the selected source plus 4*word.
    function automatic logic [31:0] model_addr(input logic [1:0] sel, input logic [2:0] cnt,
                                               input logic [31:0] ic, input logic [31:0] dc,
                                               input logic [TAG_W-1:0] tag);
        logic [31:0] base;
        case (sel)
            2'd1:    base = dc & ~32'd31;
            2'd3:    base = (32'(tag) << (IDX_W + 5)) | (dc & (((32'd1 << IDX_W) - 32'd1) << 5));
            default: base = ic & ~32'd31;
        endcase
        return base + 32'(cnt) * 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ram_en_in        = 1'b0;
        ram_write_in     = 1'b0;
        ram_addr_sel_in  = 2'd0;
        counter_in       = 3'd0;
        ic_addr_in       = '0;
        dc_addr_in       = '0;
        dc_victim_tag_in = '0;
        wdata_in         = '0;
        mem_ack_in       = 1'b0;
        mem_rdata_in     = '0;
    endtask

    // Issue a request; returns once the DUT is in its first REQ cycle.
    task automatic issue(input logic [1:0] sel, input logic [2:0] cnt, input logic [31:0] ic,
                         input logic [31:0] dc, input logic [TAG_W-1:0] tag,
                         input logic [31:0] wd, input logic wr);
        ram_en_in        = 1'b1;
        ram_write_in     = wr;
        ram_addr_sel_in  = sel;
        counter_in       = cnt;
        ic_addr_in       = ic;
        dc_addr_in       = dc;
        dc_victim_tag_in = tag;
        wdata_in         = wd;
        tick();
        ram_en_in        = 1'b0;
        ic_addr_in       = $urandom;
        dc_addr_in       = $urandom;
        counter_in       = 3'($urandom);
        wdata_in         = $urandom;
    endtask

    task automatic xfer(input string tag, input logic [1:0] sel, input logic [2:0] cnt,
                        input logic [31:0] ic, input logic [31:0] dc, input logic [TAG_W-1:0] vtag,
                        input logic [31:0] wd, input logic wr, input int delay,
                        input logic [31:0] rd);
        logic [31:0] a_exp;
        a_exp = model_addr(sel, cnt, ic, dc, vtag);
        issue(sel, cnt, ic, dc, vtag, wd, wr);
        for (int k = 0; k <= delay; k++) begin
            chk({tag, "_req"}, 32'(mem_req_out), 32'd1);
            chk({tag, "_we"}, 32'(mem_we_out), 32'(wr));
            chk({tag, "_busy"}, 32'(busy_out), 32'd1);
            chk({tag, "_addr"}, mem_addr_out, a_exp);
            if (wr) chk({tag, "_wdata"}, mem_wdata_out, wd);
            chk({tag, "_nodone"}, 32'(word_done_out), 32'd0);
            mem_ack_in   = (k == delay);
            mem_rdata_in = (k == delay) ? rd : 32'($urandom);
            tick();
        end
        mem_ack_in = 1'b0;
        if (!wr) rdata_exp = rd;
        chk({tag, "_done"}, 32'(word_done_out), 32'd1);
        chk({tag, "_done_req"}, 32'(mem_req_out), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy_out), 32'd0);
        chk({tag, "_rdata"}, rdata_out, rdata_exp);
        chk({tag, "_tmo"}, 32'(timeout_out), 32'(tmo_exp));
        tick();
        chk({tag, "_idle_done"}, 32'(word_done_out), 32'd0);
        chk({tag, "_idle_req"}, 32'(mem_req_out), 32'd0);
    endtask

    initial begin
        int req_cycles;
        logic [31:0] base;
        drive_idle();
        rst       = 1'b1;
        rdata_exp = '0;
        tmo_exp   = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(mem_req_out), 32'd0);
        chk("rst_we", 32'(mem_we_out), 32'd0);
        chk("rst_done", 32'(word_done_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_tmo", 32'(timeout_out), 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_wdata", mem_wdata_out, 32'd0);
        chk("rst_rdata", rdata_out, 32'd0);
        rst = 1'b0;
        tick();

        // Read with ack in the first REQ cycle.
        xfer("rd_imm", 2'b00, 3'd3, 32'h0040_1234, 32'h0, '0, 32'h0, 1'b0, 0, 32'hCAFE_F00D);
        chk("rd_imm_addr_const", model_addr(2'b00, 3'd3, 32'h0040_1234, 32'h0, '0), 32'h0040_122C);

        // Victim write-back with three wait cycles; rdata must not move.
        xfer("wb", 2'b11, 3'd7, 32'h0, 32'hFFFF_F000 | (32'h15 << 5), 21'h1ABCD, 32'h1234_5678,
             1'b1, 3, 32'h5555_AAAA);
        chk("wb_addr_const", model_addr(2'b11, 3'd7, 32'h0, 32'h15 << 5, 21'h1ABCD), 32'h0D5E_6ABC);

        // Full D-line refill with the counter stepping on each completion.
        base = 32'h8765_4300;
        for (int w = 0; w < 8; w++)
            xfer("refill", 2'b01, 3'(w), 32'($urandom), base | 32'h1F, '0, 32'h0, 1'b0,
                 int'($urandom_range(0, 2)), 32'h1000_0000 + 32'(w));

        // Random transfers, each preceded by an idle cycle with a stray ack.
        for (int n = 0; n < 30; n++) begin
            mem_ack_in   = 1'b1;
            mem_rdata_in = $urandom;
            tick();
            mem_ack_in = 1'b0;
            chk("stray_done", 32'(word_done_out), 32'd0);
            chk("stray_req", 32'(mem_req_out), 32'd0);
            chk("stray_rdata", rdata_out, rdata_exp);
            xfer("rand", 2'($urandom), 3'($urandom), $urandom, $urandom, TAG_W'($urandom), $urandom,
                 1'($urandom), int'($urandom_range(0, 5)), $urandom);
        end

        // Read that is never acknowledged.
        issue(2'b10, 3'd1, 32'h0000_2040, 32'h0, '0, 32'h0, 1'b0);
        chk("tmo_addr", mem_addr_out, 32'h0000_2044);
        req_cycles = 0;
        while (mem_req_out === 1'b1 && req_cycles < int'(TIMEOUT) + 10) begin
            req_cycles++;
            tick();
        end
        chk("tmo_req_cycles", 32'(req_cycles), 32'(TIMEOUT));
        tmo_exp   = 1'b1;
        rdata_exp = 32'hDEAD_BEEF;
        chk("tmo_flag", 32'(timeout_out), 32'd1);
        chk("tmo_rdata", rdata_out, 32'hDEAD_BEEF);
        chk("tmo_done", 32'(word_done_out), 32'd1);
        tick();
        chk("tmo_idle_done", 32'(word_done_out), 32'd0);
        xfer("post_tmo", 2'b01, 3'd2, 32'h0, 32'h0000_0400, '0, 32'h0, 1'b0, 1, 32'h0BAD_CAFE);

        // Reset in REQ coinciding with an ack: no completion, everything cleared.
        issue(2'b00, 3'd5, 32'h1111_1100, 32'h0, '0, 32'h0, 1'b0);
        chk("mrst_req_pre", 32'(mem_req_out), 32'd1);
        rst          = 1'b1;
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h7777_7777;
        tick();
        rst       = 1'b0;
        rdata_exp = '0;
        tmo_exp   = 1'b0;
        chk("mrst_req", 32'(mem_req_out), 32'd0);
        chk("mrst_done", 32'(word_done_out), 32'd0);
        chk("mrst_busy", 32'(busy_out), 32'd0);
        chk("mrst_tmo", 32'(timeout_out), 32'd0);
        chk("mrst_rdata", rdata_out, 32'd0);
        tick();
        mem_ack_in = 1'b0;
        chk("mrst_stray_done", 32'(word_done_out), 32'd0);
        chk("mrst_stray_req", 32'(mem_req_out), 32'd0);
        chk("mrst_stray_rdata", rdata_out, 32'd0);
        xfer("post_rst", 2'b00, 3'd0, 32'h2222_2200, 32'h0, '0, 32'h0, 1'b0, 0, 32'h3333_4444);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
